// File: rtl/counter_sequencer_if.sv
// Control/status bundle for counter_sequencer: run requests and preset in,
// registered count, strobes and FSM state out.
interface counter_sequencer_if;
   logic       start;
   logic       stop;
   logic       dir;
   logic [1:0] mode;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic [3:0] count_n;
   logic       tick;
   logic       tc;
   logic       busy;
   logic [1:0] state;

   modport master (
      output start, stop, dir, mode, load, load_val,
      input  count, count_n, tick, tc, busy, state
   );

   modport slave (
      input  start, stop, dir, mode, load, load_val,
      output count, count_n, tick, tc, busy, state
   );
endinterface

// File: rtl/counter_sequencer.sv
// Prescaled 4-bit up/down counter with run/pause/done sequencing and
// wrap, one-shot and ping-pong terminal behaviour; all outputs registered.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; load presets count, start enters RUN latching dir
// RUN   | prescaler running, count steps once per TICK_DIV cycles
// PAUSE | count held; start resumes with direction kept, stop -> IDLE
// DONE  | one-shot finished; start restarts from 0 (up) or 15 (down)
module counter_sequencer #(
   parameter int unsigned TICK_DIV = 32'd50_000_000
) (
   input logic              CLOCK_50,
   input logic              rst_n,
   counter_sequencer_if.slave sif
);

   localparam logic [1:0]  S_IDLE   = 2'b00;
   localparam logic [1:0]  S_RUN    = 2'b01;
   localparam logic [1:0]  S_PAUSE  = 2'b10;
   localparam logic [1:0]  S_DONE   = 2'b11;
   localparam logic [31:0] PRE_LAST = TICK_DIV - 32'd1;

   logic [1:0]  state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [3:0]  count_n_q, count_n_d;
   logic        down_q, down_d;
   logic [31:0] pre_q, pre_d;
   logic        tick_q, tick_d;
   logic        tc_q, tc_d;
   logic        busy_q, busy_d;

   logic        step;
   logic [3:0]  stepped;
   logic        at_term;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= 4'd0;
         count_n_q <= 4'hF;
         down_q    <= 1'b0;
         pre_q     <= 32'd0;
         tick_q    <= 1'b0;
         tc_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         count_n_q <= count_n_d;
         down_q    <= down_d;
         pre_q     <= pre_d;
         tick_q    <= tick_d;
         tc_q      <= tc_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      step    = (state_q == S_RUN) && (pre_q == PRE_LAST);
      stepped = down_q ? (count_q - 4'd1) : (count_q + 4'd1);
      at_term = down_q ? (stepped == 4'd0) : (stepped == 4'hF);
      state_d = state_q;
      count_d = count_q;
      down_d  = down_q;
      pre_d   = 32'd0;
      case (state_q)
         S_IDLE: begin
            if (!sif.stop) begin
               if (sif.load) begin
                  count_d = sif.load_val;
               end else if (sif.start) begin
                  state_d = S_RUN;
                  down_d  = sif.dir;
               end
            end
         end
         S_RUN: begin
            pre_d = step ? 32'd0 : (pre_q + 32'd1);
            if (step) begin
               count_d = stepped;
               if (at_term) begin
                  if (sif.mode == 2'b01) begin
                     state_d = S_DONE;
                  end else if (sif.mode == 2'b10) begin
                     down_d = ~down_q;
                  end
               end
            end
            // A coincident stop still lets the step land, then parks in PAUSE.
            if (sif.stop) begin
               state_d = S_PAUSE;
               pre_d   = 32'd0;
            end
         end
         default: begin
            if (sif.stop) begin
               state_d = S_IDLE;
            end else if (sif.load) begin
               count_d = sif.load_val;
            end else if (sif.start) begin
               state_d = S_RUN;
               if (state_q == S_DONE) begin
                  count_d = down_q ? 4'hF : 4'h0;
               end
            end
         end
      endcase
   end

   always_comb begin
      busy_d    = (state_d == S_RUN);
      tick_d    = (state_d == S_RUN) && (pre_d == PRE_LAST);
      tc_d      = step && at_term;
      count_n_d = ~count_d;
   end

   assign sif.count   = count_q;
   assign sif.count_n = count_n_q;
   assign sif.tick    = tick_q;
   assign sif.tc      = tc_q;
   assign sif.busy    = busy_q;
   assign sif.state   = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios with literal expectations,
// then random stimulus, all checked every cycle against a behavioural model.
module tb_counter_sequencer;
   localparam int TD = 4;

   logic CLOCK_50 = 1'b0;
   logic rst_n    = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   counter_sequencer_if sif ();

   counter_sequencer #(.TICK_DIV(TD)) dut (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .sif      (sif)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE; m_cyc = edges spent in RUN since entry.
   int m_st, m_cnt, m_down, m_cyc, m_tc;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual %0d, required %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      int nst;
      bit stepping;
      nst  = m_st;
      m_tc = 0;
      if (m_st == 1) begin
         stepping = (m_cyc % TD) == (TD - 1);
         m_cyc++;
         if (stepping) begin
            m_cnt = m_down ? (m_cnt + 15) % 16 : (m_cnt + 1) % 16;
            if (m_cnt == (m_down ? 0 : 15)) begin
               m_tc = 1;
               if (sif.mode == 2'd1) nst = 3;
               else if (sif.mode == 2'd2) m_down = 1 - m_down;
            end
         end
         if (sif.stop) nst = 2;
      end else begin
         if (sif.stop) begin
            nst = 0;
         end else if (sif.load) begin
            m_cnt = int'(sif.load_val);
         end else if (sif.start) begin
            if (m_st == 0) m_down = int'(sif.dir);
            if (m_st == 3) m_cnt = m_down ? 15 : 0;
            nst   = 1;
            m_cyc = 0;
         end
      end
      m_st = nst;
   endtask

   always @(posedge CLOCK_50) begin
      if (!rst_n) begin
         m_st = 0; m_cnt = 0; m_down = 0; m_cyc = 0; m_tc = 0;
      end else begin
         model_step();
      end
      #1;
      chk("state",   int'(sif.state),   m_st);
      chk("count",   int'(sif.count),   m_cnt);
      chk("count_n", int'(sif.count_n), 15 - m_cnt);
      chk("busy",    int'(sif.busy),    (m_st == 1) ? 1 : 0);
      chk("tick",    int'(sif.tick),    (m_st == 1 && (m_cyc % TD) == TD - 1) ? 1 : 0);
      chk("tc",      int'(sif.tc),      m_tc);
   end

   task automatic step_clk(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step_clk(1);
      rst_n = 1'b1;
      step_clk(1);
   endtask

   task automatic pulse_start();
      sif.start = 1'b1;
      step_clk(1);
      sif.start = 1'b0;
   endtask

   initial begin
      sif.start = 1'b0; sif.stop = 1'b0; sif.dir = 1'b0; sif.mode = 2'd0;
      sif.load = 1'b0; sif.load_val = 4'd0;
      step_clk(2);
      chk("rst_count_n", int'(sif.count_n), 15);
      chk("rst_state", int'(sif.state), 0);
      rst_n = 1'b1;
      step_clk(1);

      // Wrap, counting up
      sif.dir = 1'b0; sif.mode = 2'd0;
      pulse_start();
      chk("s1_busy", int'(sif.busy), 1);
      chk("s1_count0", int'(sif.count), 0);
      step_clk(3);
      chk("s1_first_tick", int'(sif.tick), 1);
      step_clk(57);
      chk("s1_count15", int'(sif.count), 15);
      chk("s1_tc", int'(sif.tc), 1);
      step_clk(1);
      chk("s1_tc_one_cycle", int'(sif.tc), 0);
      step_clk(3);
      chk("s1_wrap0", int'(sif.count), 0);
      step_clk(4);
      chk("s1_count1", int'(sif.count), 1);

      // One-shot, counting down from a preset
      do_reset();
      sif.load_val = 4'd3; sif.load = 1'b1;
      step_clk(1);
      sif.load = 1'b0;
      chk("s2_load", int'(sif.count), 3);
      chk("s2_load_idle", int'(sif.state), 0);
      sif.dir = 1'b1; sif.mode = 2'd1;
      pulse_start();
      step_clk(12);
      chk("s2_count0", int'(sif.count), 0);
      chk("s2_tc", int'(sif.tc), 1);
      chk("s2_done", int'(sif.state), 3);
      step_clk(2);
      chk("s2_held", int'(sif.count), 0);
      pulse_start();
      chk("s2_restart15", int'(sif.count), 15);
      chk("s2_restart_run", int'(sif.state), 1);

      // Ping-pong from 13
      do_reset();
      sif.mode = 2'd2; sif.dir = 1'b0; sif.load_val = 4'd13; sif.load = 1'b1;
      step_clk(1);
      sif.load = 1'b0;
      pulse_start();
      step_clk(8);
      chk("s3_top", int'(sif.count), 15);
      chk("s3_top_tc", int'(sif.tc), 1);
      step_clk(60);
      chk("s3_bottom", int'(sif.count), 0);
      chk("s3_bottom_tc", int'(sif.tc), 1);
      step_clk(4);
      chk("s3_bounce", int'(sif.count), 1);

      // Stop coincident with tick, then resume
      do_reset();
      sif.mode = 2'd0; sif.dir = 1'b0;
      pulse_start();
      step_clk(23);
      chk("s4_pre_count", int'(sif.count), 5);
      sif.stop = 1'b1;
      step_clk(1);
      sif.stop = 1'b0;
      chk("s4_stepped", int'(sif.count), 6);
      chk("s4_pause", int'(sif.state), 2);
      step_clk(5);
      chk("s4_held", int'(sif.count), 6);
      pulse_start();
      step_clk(3);
      chk("s4_not_yet", int'(sif.count), 6);
      step_clk(1);
      chk("s4_resume_step", int'(sif.count), 7);

      // Priority stop > load > start
      sif.stop = 1'b1;
      step_clk(1);
      chk("s5_pause", int'(sif.state), 2);
      sif.load_val = 4'd9; sif.load = 1'b1; sif.start = 1'b1;
      step_clk(1);
      chk("s5_idle", int'(sif.state), 0);
      chk("s5_count_kept", int'(sif.count), 7);
      sif.stop = 1'b0;
      step_clk(1);
      chk("s5_loaded", int'(sif.count), 9);
      chk("s5_still_idle", int'(sif.state), 0);
      sif.load = 1'b0; sif.start = 1'b0;

      // Asynchronous reset mid-RUN
      do_reset();
      pulse_start();
      step_clk(36);
      chk("s6_count9", int'(sif.count), 9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6_state", int'(sif.state), 0);
      chk("s6_count", int'(sif.count), 0);
      chk("s6_count_n", int'(sif.count_n), 15);
      chk("s6_busy", int'(sif.busy), 0);
      chk("s6_tick", int'(sif.tick), 0);
      chk("s6_tc", int'(sif.tc), 0);
      step_clk(2);
      rst_n = 1'b1;
      step_clk(3);
      chk("s6_waits_idle", int'(sif.state), 0);

      // Random stimulus
      for (int i = 0; i < 4000; i++) begin
         sif.start    = ($urandom_range(0, 3) == 0);
         sif.stop     = ($urandom_range(0, 15) == 0);
         sif.load     = ($urandom_range(0, 7) == 0);
         sif.load_val = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) begin
            sif.dir  = 1'($urandom_range(0, 1));
            sif.mode = 2'($urandom_range(0, 3));
         end
         rst_n = ($urandom_range(0, 599) != 0);
         step_clk(1);
      end
      rst_n = 1'b1;
      step_clk(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: TICK_DIV, default 50_000_000, CLOCK_50 cycles per count step (1 Hz at 50 MHz); legal range 2..2^32-1.
REQ-002 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level, sampled each edge; run/resume/restart request.
REQ-005 stop  input  1  level, sampled each edge; pause/abort request.
REQ-006 dir  input  1  0 = up, 1 = down; latched only on IDLE->RUN.
REQ-007 mode  input  2  00 wrap, 01 one-shot, 10 ping-pong, 11 treated as wrap.
REQ-008 load  input  1  preset request.
REQ-009 load_val  input  4  preset value.
REQ-010 count  output  4  current count (true outputs).
REQ-011 count_n  output  4  bitwise complement of count.
REQ-012 tick  output  1  one-cycle step strobe.
REQ-013 tc  output  1  one-cycle terminal-count strobe.
REQ-014 busy  output  1  high only in RUN.
REQ-015 state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-016 The block SHALL implement the four-state FSM of REQ-015, all outputs registered, count_n = ~count in every cycle.
REQ-017 IDLE: start -> RUN next edge, internal direction <= dir, prescaler <= 0.
REQ-018 RUN: stop -> PAUSE; start ignored; load ignored.
REQ-019 PAUSE: start -> RUN (prescaler cleared, direction retained); stop -> IDLE; count held.
REQ-020 DONE: count held; start -> RUN with count <= 0 if direction up, 15 if down; stop -> IDLE.
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, held at 0 elsewhere; tick high for the one cycle in which prescaler == TICK_DIV-1 in RUN.
REQ-022 First step occurs TICK_DIV cycles after the edge entering RUN; subsequent steps every TICK_DIV cycles.
REQ-023 On each tick count SHALL step +1 (up) or -1 (down) modulo 16 (15+1 = 0, 0-1 = 15).
REQ-024 Terminal value: 15 when up, 0 when down; tc SHALL be high in exactly the first cycle count shows terminal value from a step (not from load/restart).
REQ-025 On terminal step: wrap mode stays RUN; one-shot enters DONE same edge; ping-pong stays RUN and inverts direction so the next step moves away from terminal.
REQ-026 load in IDLE, PAUSE or DONE: count <= load_val next edge, state unchanged, no tc.
REQ-027 Simultaneous requests priority: stop > load > start; lower-priority requests in that cycle are dropped.
REQ-028 stop in the same cycle as tick: the step is taken (count and tc update), then state = PAUSE.
REQ-029 Level-held start/stop SHALL act once per transition: each state change requires the request to be sampled in the new state.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, count 0, count_n 4'hF, tick 0, tc 0, busy 0, direction up, prescaler 0, irrespective of clock.
REQ-031 Reset asserted mid-RUN SHALL abort with no further tick/tc; after release the block waits in IDLE for start.

Verification (TICK_DIV = 4)
REQ-032 Reset, start=1 one cycle, dir=0, mode=00 -> tick every 4 cycles, count 0,1,...,15 (tc once), 0,1; busy=1.
REQ-033 load_val=3 load in IDLE, start with dir=1, mode=01 -> count 2,1,0, tc at 0, state DONE, count held 0; start -> count 15, RUN.
REQ-034 mode=10, dir=0, load 13, start -> count 14,15(tc),14,13,...,0(tc),1.
REQ-035 Running at count 5: stop coincident with tick -> count 6, state PAUSE, no further ticks; start -> next step exactly 4 cycles later to 7.
REQ-036 stop, load and start asserted together in PAUSE -> IDLE, count unchanged; load+start in IDLE -> count=load_val, still IDLE.
REQ-037 rst_n pulled low between clock edges during RUN at count 9 -> all outputs reset values immediately, count_n=4'hF.
